mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative multiply/divide unit: the responder for the integer pipeline's mul/div requests.
- Replaces the temporary single-cycle ALU opcodes 4'hE/4'hF.
- Accepts one request via valid/ready, runs a radix-2 shift-add (multiply) or restoring (divide) loop one bit per cycle, and returns the result plus a 4-bit flag nibble via valid/ready.
- Sits beside the ALU; the issue stage stalls on ReqReady.

Parameters:
- WIDTH, 32: operand/result width; the loop iteration count equals WIDTH.

Ports:
- Clock  in  1  rising-edge clock
- ResetN  in  1  synchronous active-low reset
- Flush  in  1  abandon any in-flight operation
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept
- Operation  in  3  0 MUL, 1 MULH, 2 MULHU, 3 MULHSU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- Operand1  in  WIDTH  multiplicand/dividend
- Operand2  in  WIDTH  multiplier/divisor
- RespValid  out  1  result present
- RespReady  in  1  consumer accepts result
- Result  out  WIDTH  result
- Flags  out  4  [0] zero, [1] negative (Result MSB), [2] divide-by-zero, [3] signed-divide overflow

Behaviour:
- Clock/reset (already decided): one clock, Clock; reset is synchronous and active-low, ResetN. With ResetN low at an edge:
  - state goes to IDLE;
  - ReqReady=0 during reset, 1 from the first cycle after ResetN is sampled high;
  - RespValid=0, Result=0, Flags=0, counter=0.
  - Reset mid-operation discards the operation silently.
- States: IDLE -> BUSY -> FIXUP -> DONE -> IDLE.
- IDLE: ReqReady=1. On ReqValid&&ReqReady, latch the op. For signed operand positions, latch operand magnitudes plus sign bits. Clear accumulator and counter, go to BUSY.
- BUSY: one iteration per cycle; after WIDTH iterations go to FIXUP.
  - Multiply: 2*WIDTH product register.
  - Divide: WIDTH remainder, WIDTH quotient.
- FIXUP: one cycle.
  - Apply sign correction: product negated if the signs differ; quotient sign = s1^s2; remainder sign = s1.
  - Select low/high half or quotient/remainder.
  - Compute Flags; go to DONE.
- DONE: RespValid=1 with Result/Flags held stable until RespReady. On RespValid&&RespReady go to IDLE.
  - ReqReady=0 in DONE; no same-cycle accept.
- Latency: RespValid rises WIDTH+2 edges after the accepting edge (34 at WIDTH=32). Throughput is one op per WIDTH+3 cycles minimum.
- ReqReady=0 in BUSY/FIXUP/DONE. Operands are captured only at accept; later input changes are ignored.
- Divide by zero:
  - DIV/DIVU return all ones; REM/REMU return Operand1; Flags[2]=1.
  - The loop still runs the full latency.
- Signed overflow, DIV/REM with Operand1=MIN and Operand2=-1:
  - DIV returns MIN; REM returns 0; Flags[3]=1.
- MULHSU: Operand1 signed, Operand2 unsigned.
- Flags[0] = (Result==0). Flags[1] = Result[WIDTH-1]. Flags[2] and Flags[3] are 0 for multiply ops.
- Flush (any state): next edge goes to IDLE and RespValid=0; no response is produced.
  - Flush has priority over ReqValid and RespReady in the same cycle.
  - Flush in IDLE with ReqValid blocks the accept.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: these cases skip BUSY and go IDLE -> FIXUP, giving RespValid 2 edges after accept:
  - divide-by-zero;
  - signed overflow;
  - multiply with either operand zero.
- Results and flags are identical to the full-latency path.
- Undefined: every op takes the full WIDTH+2 latency. Result and flag values are unchanged either way.

Decomposition:
- Package mdu_pkg holds:
  - typedef enum mdu_op_t (8 opcodes above);
  - typedef enum mdu_state_t {IDLE, BUSY, FIXUP, DONE};
  - flag bit index constants FLAG_Z=0, FLAG_N=1, FLAG_DZ=2, FLAG_OV=3.
- Sub-module mdu_step: combinational single iteration (add-shift or compare-subtract-shift) taking op class and the current accumulator; mdu_iter owns the registers and FSM.

Test Plan:
- MUL 7 x 6, RespReady=1 -> RespValid at edge 34 after accept; Result=42; Flags=0000.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> Result=0 (high of +1), Flags[0]=1. MULHU same operands -> Result=0xFFFFFFFE, Flags[1]=1.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1), Flags[1]=1. DIVU 100/7 -> 14.
- DIVU 5/0 -> 0xFFFFFFFF, Flags[2]=1, Flags[1]=1. REM 0x80000000/0xFFFFFFFF -> 0, Flags[3]=1, Flags[0]=1. With MDU_EARLY_OUT_EN: RespValid at edge 2.
- Back-pressure and re-issue: hold RespReady=0 for 10 cycles -> Result/Flags stable, ReqReady=0. Release -> ReqReady=1 the next cycle; a new request is accepted.
- Flush at BUSY cycle 10, then ResetN low at BUSY cycle 5 of the next op -> no RespValid either time; IDLE/ReqReady=1 afterwards; outputs 0 after reset.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode/state types, flag bit positions and opcode helpers
// for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHU  = 3'd2,
        OP_MULHSU = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_t;

    localparam int FLAG_Z  = 0;
    localparam int FLAG_N  = 1;
    localparam int FLAG_DZ = 2;
    localparam int FLAG_OV = 3;

    // Upper half of the opcode space is the divide/remainder class.
    function automatic logic op_is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic op1_is_signed(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op2_is_signed(input mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the unsigned-magnitude loop.
// Multiply: {acc_hi,acc_lo} is the product register with the multiplier in
// acc_lo; conditionally add the multiplicand to the top half, shift right.
// Divide: acc_hi is the partial remainder, acc_lo the dividend/quotient;
// shift left, trial-subtract the divisor, keep it if it did not borrow.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Single add-shift or compare-subtract-shift step.
    always_comb begin
        addend  = acc_lo[0] ? operand : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, operand});
        // Partial remainder stays below the divisor, so a successful
        // subtraction always fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - operand;
        nxt_hi  = sum[WIDTH:1];
        nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            nxt_hi = ge ? diff : shifted[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply / restoring divide unit with
// valid/ready request and response channels.
// Build option: define MDU_EARLY_OUT_EN to send divide-by-zero, signed
// overflow and zero-operand multiplies straight from IDLE to FIXUP.
//
// state | meaning
// IDLE  | ready for a request; operands captured on accept
// BUSY  | one loop iteration per cycle, WIDTH iterations
// FIXUP | sign correction, result select, flag generation
// DONE  | response presented and held until RespReady
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Flush,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [2:0]       Operation,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t         state, state_nxt;
    mdu_op_t            op_in, op_q;
    logic               rst_done, accept, early_req;
    logic               div_in, s1_in, s2_in, dz_in, ov_in, mz_in;
    logic [WIDTH-1:0]   mag1_in, mag2_in;
    logic               s1_q, s2_q, dz_q, ov_q, mz_q, div_q;
    logic [WIDTH-1:0]   mag1_q, mag2_q, acc_hi, acc_lo;
    logic [WIDTH-1:0]   step_hi, step_lo, step_opnd;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, op1_orig, res, result_q;
    logic [3:0]         flags_nxt, flags_q;

    assign op_in     = mdu_op_t'(Operation);
    assign ReqReady  = rst_done && (state == IDLE);
    assign accept    = ReqValid && ReqReady && !Flush;
    assign RespValid = (state == DONE);
    assign Result    = result_q;
    assign Flags     = flags_q;
    assign div_q     = op_is_div(op_q);
    assign step_opnd = div_q ? mag2_q : mag1_q;

`ifdef MDU_EARLY_OUT_EN
    assign early_req = dz_in | ov_in | mz_in;
`else
    assign early_req = 1'b0;
`endif

    // Operand signs/magnitudes and special-case detection at the request port.
    always_comb begin
        div_in  = op_is_div(op_in);
        s1_in   = op1_is_signed(op_in) & Operand1[WIDTH-1];
        s2_in   = op2_is_signed(op_in) & Operand2[WIDTH-1];
        mag1_in = s1_in ? -Operand1 : Operand1;
        mag2_in = s2_in ? -Operand2 : Operand2;
        dz_in   = div_in && (Operand2 == '0);
        ov_in   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (Operand1 == MIN_VAL) && (Operand2 == '1);
        mz_in   = !div_in && ((Operand1 == '0) || (Operand2 == '0));
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (div_q),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (step_opnd),
        .nxt_hi  (step_hi),
        .nxt_lo  (step_lo)
    );

    // State register; rst_done keeps ReqReady low until reset release is seen.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state    <= IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
        end
    end

    // Next-state logic; Flush overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (Flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = early_req ? FIXUP : BUSY;
                BUSY:    if (cnt == CNT_LAST) state_nxt = FIXUP;
                FIXUP:   state_nxt = DONE;
                DONE:    if (RespReady) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Sign correction, result select and flags from the finished loop state.
    // Special cases are forced here so the early-out path needs no loop data.
    always_comb begin
        prod_fix = (s1_q ^ s2_q) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix  = (s1_q ^ s2_q) ? -acc_lo : acc_lo;
        rem_fix  = s1_q ? -acc_hi : acc_hi;
        op1_orig = s1_q ? -mag1_q : mag1_q;
        res      = '0;
        case (op_q)
            OP_MUL:                       res = mz_q ? '0 : prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU: res = mz_q ? '0 : prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              res = dz_q ? '1 : (ov_q ? MIN_VAL : quo_fix);
            default:                      res = dz_q ? op1_orig : (ov_q ? '0 : rem_fix);
        endcase
        flags_nxt          = '0;
        flags_nxt[FLAG_Z]  = (res == '0);
        flags_nxt[FLAG_N]  = res[WIDTH-1];
        flags_nxt[FLAG_DZ] = dz_q;
        flags_nxt[FLAG_OV] = ov_q;
    end

    // Operand capture, loop iteration and result/flag registers.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            op_q     <= OP_MUL;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
            mz_q     <= 1'b0;
            mag1_q   <= '0;
            mag2_q   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        s1_q   <= s1_in;
                        s2_q   <= s2_in;
                        dz_q   <= dz_in;
                        ov_q   <= ov_in;
                        mz_q   <= mz_in;
                        mag1_q <= mag1_in;
                        mag2_q <= mag2_in;
                        acc_hi <= '0;
                        acc_lo <= div_in ? mag1_in : mag2_in;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (!Flush) begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + 1'b1;
                    end
                end
                FIXUP: begin
                    if (!Flush) begin
                        result_q <= res;
                        flags_q  <= flags_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
